// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and helpers for the multi-channel PWM
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        UP,
        DOWN
    } pwm_state_e;

    function automatic int ch_width(int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Phase offset of channel i so the channels spread evenly over one period
    function automatic int stagger_offset(int i, int width, int channels);
        return i * ((1 << width) / channels);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: shadow/active duty, compare and output flop
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             commit,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             idle,
    output logic             pwm
);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] duty_now;

    // The commit cycle already belongs to the new period, so it compares
    // against the value being committed rather than the outgoing one.
    assign duty_now = commit ? shadow : active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow <= duty_in;
            end
            if (commit) begin
                active <= shadow;
            end
            pwm <= idle ? 1'b0 : (cnt_i < duty_now);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shared counter, centre mode and stagger
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int  WIDTH    = 16,
    parameter int  CHANNELS = 4,
    parameter int  STAGGER  = 1,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                center_mode,
    input  logic                load,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [WIDTH-1:0]    duty_in,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic                mode_active
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    pwm_state_e       state;
    logic [WIDTH-1:0] cnt;
    logic             commit;
    logic             idle;
    logic             eff_center;

    assign commit     = (state == COMMIT);
    assign idle       = (state == IDLE) || !enable;
    assign eff_center = commit ? center_mode : mode_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            period_start <= 1'b0;
            mode_active  <= 1'b0;
        end else if (!enable) begin
            state        <= IDLE;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= 1'b0;
            case (state)
                IDLE: begin
                    state        <= COMMIT;
                    cnt          <= '0;
                    period_start <= 1'b1;
                end
                COMMIT: begin
                    mode_active <= center_mode;
                    state       <= UP;
                    cnt         <= ONE;
                end
                UP: begin
                    if (cnt == CNT_MAX) begin
                        if (mode_active) begin
                            state <= DOWN;
                            cnt   <= cnt - ONE;
                        end else begin
                            state        <= COMMIT;
                            cnt          <= '0;
                            period_start <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DOWN: begin
                    if (cnt == ONE) begin
                        state        <= COMMIT;
                        cnt          <= '0;
                        period_start <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [WIDTH-1:0] OFFSET =
            (STAGGER != 0) ? WIDTH'(stagger_offset(i, WIDTH, CHANNELS)) : '0;

        logic [WIDTH-1:0] cnt_i;
        logic             wr_en;

        // Centre mode mirrors the count so pulses sit symmetrically about the peak
        assign cnt_i = eff_center ? ~cnt : cnt + OFFSET;
        assign wr_en = load && (load_ch == CH_W'(i));

        pwm_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .cnt_i   (cnt_i),
            .commit  (commit),
            .wr_en   (wr_en),
            .duty_in (duty_in),
            .idle    (idle),
            .pwm     (pwm_out[i])
        );
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel successor to the single-channel 16-bit PWM.
- Generates CHANNELS PWM outputs from one shared period counter of WIDTH bits.
- Supports edge-aligned or centre-aligned mode, optional per-channel phase staggering, and glitch-free double-buffered duty updates committed only at period boundaries.
- Sits between the DSP duty-cycle source(s) and the pwm output pins, in the fast PWM clock domain.

Parameters:
- WIDTH, 16, counter/duty width in bits; period = 2^WIDTH cycles (edge mode) or 2*(2^WIDTH-1) cycles (centre mode).
- CHANNELS, 4, number of PWM outputs (1..16).
- STAGGER, 1, when 1 in edge mode, channel i compares against (cnt + i*(2^WIDTH/CHANNELS)) mod 2^WIDTH; when 0, no offset.

Ports:
- clk  in  1  PWM clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run counter; low forces idle
- center_mode  in  1  requested mode; sampled only at a period boundary
- load  in  1  single-cycle strobe: write duty_in to the shadow register of load_ch
- load_ch  in  $clog2(CHANNELS) (min 1)  target channel for load
- duty_in  in  WIDTH  new duty value
- pwm_out  out  CHANNELS  registered PWM outputs
- period_start  out  1  one-cycle pulse on the cycle the commit occurs
- mode_active  out  1  mode currently in effect (1 = centre)

Behaviour:
- Reset (async assert, sync release): cnt=0, state=IDLE, all shadow/active duties=0, pwm_out=0, period_start=0, mode_active=0.
- FSM states:
  - IDLE: cnt held at 0, outputs 0. When enable=1, go to COMMIT.
  - COMMIT: active<=shadow for all channels; mode_active<=center_mode; period_start=1. Next state is UP. cnt=0 for this cycle.
  - UP: cnt increments each cycle.
    - Edge mode: at cnt=2^WIDTH-1, return to COMMIT (next cnt=0). The COMMIT cycle counts as the cycle with cnt=0, so the period is exactly 2^WIDTH cycles.
    - Centre mode: at cnt=2^WIDTH-1, go to DOWN.
  - DOWN: cnt decrements each cycle; at cnt=1, go to COMMIT (next cnt=0).
  - Any state: enable=0 goes to IDLE on the next clock, and cnt clears to 0.
- Compare, per channel: raw = (cnt_i < active_i), where cnt_i includes the stagger offset in edge mode only. pwm_out[i] <= raw, giving 1 cycle latency from counter to pin. While in IDLE, pwm_out <= 0.
- Duty boundaries:
  - duty=0 keeps the output permanently low.
  - Edge mode: duty=2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH cycles; 100% is not reachable, by design.
  - Centre mode: high time = 2*duty-1 cycles for duty>0, symmetric about cnt=max.
- Load:
  - A load strobe updates shadow[load_ch] at the clock edge.
  - A load in the same cycle as COMMIT: the commit takes the old shadow value; the new value applies from the following period.
  - Multiple loads within a period: last write wins.
  - load_ch >= CHANNELS: ignored.
  - Loads are accepted in IDLE as well.
- Mode changes take effect only at COMMIT, so a period is never truncated.
- Stagger: offsets wrap modulo 2^WIDTH. All channels still commit at the global boundary, so a staggered channel may see its duty change mid-pulse; this is accepted and documented.
- No combinational path from inputs to outputs.

Decomposition:
- Package pwm_pkg:
  - pwm_state_e enum {IDLE, COMMIT, UP, DOWN}.
  - Function stagger_offset(i, WIDTH, CHANNELS).
  - localparam CH_W = (CHANNELS>1) ? $clog2(CHANNELS) : 1.
- Sub-module pwm_channel:
  - Holds shadow/active registers, compare and output flop.
  - Inputs: cnt_i, commit, wr_en, duty_in, idle.
  - Instantiated CHANNELS times by generate.
- The top module holds the counter, FSM, decode and stagger adders.

Test Plan (WIDTH=4, CHANNELS=2 unless stated):
- Reset/idle: hold rst_n=0 then release with enable=0 -> pwm_out=0, period_start never pulses; assert rst_n mid-period -> all outputs 0 immediately (async).
- Edge, STAGGER=0: load ch0=5, ch1=0, enable, edge mode -> period_start every 16 cycles; ch0 high exactly 5 cycles per period starting 1 cycle after COMMIT; ch1 always low.
- Double buffer: with ch0=5 running, load ch0=12 mid-period, and separately load on the COMMIT cycle -> the mid-period load takes effect at the next boundary; the COMMIT-cycle load is delayed one further period; no period ever shows a mixed width.
- Centre mode: center_mode=1, ch0=3 -> period 30 cycles; ch0 high 5 cycles centred on cnt=15; toggling center_mode mid-period changes mode_active only at the next period_start.
- Stagger: STAGGER=1, CHANNELS=2, both duty=8, edge mode -> ch1 rising edge lags ch0 by 8 cycles; both 50% duty.
- Enable drop and edge cases: deassert enable mid-UP -> outputs 0 one cycle later; re-enable -> fresh COMMIT at cnt=0; duty=15 (edge) -> high 15/16 cycles; load_ch=3 with CHANNELS=3 -> ignored.
